// File: rtl/approx_stats_pkg.sv
// rtl/approx_stats_pkg.sv - shared constants and FSM state type for the error-statistics unit
package approx_stats_pkg;

    localparam int SCALE   = 100;
    localparam int SCALE_W = 7;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIV    = 2'd1,
        ACC    = 2'd2,
        REPORT = 2'd3
    } state_t;

endpackage

// File: rtl/seq_divider.sv
// rtl/seq_divider.sv - restoring divider, one quotient bit per cycle, fixed NUM_W-cycle latency
module seq_divider #(
    parameter int NUM_W = 15,
    parameter int DEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] numerator,
    input  logic [DEN_W-1:0] denominator,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] quotient
);

    localparam int CNT_W = $clog2(NUM_W);

    logic [DEN_W-1:0] rem;
    logic [DEN_W-1:0] den;
    logic [NUM_W-1:0] quo;
    logic [CNT_W-1:0] cnt;
    logic [DEN_W:0]   shifted;
    logic             fits;
    logic [DEN_W-1:0] diff;

    // Remainder stays below den, so the subtraction fits in DEN_W bits whenever it is taken.
    assign shifted  = {rem, quo[NUM_W-1]};
    assign fits     = shifted >= {1'b0, den};
    assign diff     = shifted[DEN_W-1:0] - den;
    // done marks the cycle whose closing edge writes the last quotient bit.
    assign done     = busy && (cnt == CNT_W'(NUM_W - 1));
    assign quotient = quo;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= 1'b0;
            rem  <= '0;
            den  <= '0;
            quo  <= '0;
            cnt  <= '0;
        end else if (start) begin
            busy <= 1'b1;
            rem  <= '0;
            den  <= denominator;
            quo  <= numerator;
            cnt  <= '0;
        end else if (busy) begin
            rem  <= fits ? diff : shifted[DEN_W-1:0];
            quo  <= {quo[NUM_W-2:0], fits};
            cnt  <= cnt + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/approx_error_stats.sv
// rtl/approx_error_stats.sv - windowed relative-error statistics over (approx, exact) product pairs
module approx_error_stats
    import approx_stats_pkg::*;
#(
    parameter int W      = 8,
    parameter int N_LOG2 = 8,
    parameter int SUM_W  = 24
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      approx,
    input  logic [W-1:0]      exact,
    output logic              stats_valid,
    output logic [SUM_W-1:0]  sum_rel_err,
    output logic [SUM_W-1:0]  mean_rel_err,
    output logic [N_LOG2:0]   err_count,
    output logic [N_LOG2:0]   zero_exact_count,
    output logic [W-1:0]      max_err_dist
);

    localparam int NUM_W = W + SCALE_W;
    localparam logic [N_LOG2:0] WIN_LEN = {1'b1, {N_LOG2{1'b0}}};
    localparam logic [SUM_W-1:0] SUM_MAX = '1;

    state_t            state;
    logic [W-1:0]      exact_r;
    logic [W-1:0]      d_r;
    logic [SUM_W-1:0]  sum_acc;
    logic [N_LOG2:0]   err_acc;
    logic [N_LOG2:0]   zero_acc;
    logic [N_LOG2:0]   cnt;
    logic [W-1:0]      max_acc;

    logic              accept;
    logic [W-1:0]      d_in;
    logic [NUM_W-1:0]  num_in;
    logic              div_rst;
    logic              div_busy;
    logic              div_done;
    logic [NUM_W-1:0]  quotient;

    logic [SUM_W:0]    sum_wide;
    logic [SUM_W-1:0]  sum_nxt;
    logic [N_LOG2:0]   err_nxt;
    logic [N_LOG2:0]   zero_nxt;
    logic [N_LOG2:0]   cnt_nxt;
    logic [W-1:0]      max_nxt;

    assign in_ready = (state == IDLE) && !rst && !clear;
    assign accept   = in_valid && in_ready;
    assign d_in     = (approx >= exact) ? (approx - exact) : (exact - approx);
    assign num_in   = NUM_W'(d_in) * NUM_W'(SCALE);
    assign div_rst  = rst || clear;

    seq_divider #(
        .NUM_W (NUM_W),
        .DEN_W (W)
    ) u_div (
        .clk         (clk),
        .rst         (div_rst),
        .start       (accept && (exact != '0)),
        .numerator   (num_in),
        .denominator (exact),
        .busy        (div_busy),
        .done        (div_done),
        .quotient    (quotient)
    );

    always_comb begin
        sum_wide = {1'b0, sum_acc};
        if (exact_r != '0)
            sum_wide = {1'b0, sum_acc} + (SUM_W + 1)'(quotient);
        sum_nxt  = sum_wide[SUM_W] ? SUM_MAX : sum_wide[SUM_W-1:0];
        err_nxt  = err_acc + (N_LOG2 + 1)'(d_r != '0);
        zero_nxt = zero_acc + (N_LOG2 + 1)'(exact_r == '0);
        cnt_nxt  = cnt + 1'b1;
        max_nxt  = (d_r > max_acc) ? d_r : max_acc;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state            <= IDLE;
            exact_r          <= '0;
            d_r              <= '0;
            sum_acc          <= '0;
            err_acc          <= '0;
            zero_acc         <= '0;
            cnt              <= '0;
            max_acc          <= '0;
            stats_valid      <= 1'b0;
            sum_rel_err      <= '0;
            mean_rel_err     <= '0;
            err_count        <= '0;
            zero_exact_count <= '0;
            max_err_dist     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        exact_r <= exact;
                        d_r     <= d_in;
                        state   <= (exact != '0) ? DIV : ACC;
                    end
                end
                DIV: begin
                    if (div_busy && div_done)
                        state <= ACC;
                end
                ACC: begin
                    sum_acc  <= sum_nxt;
                    err_acc  <= err_nxt;
                    zero_acc <= zero_nxt;
                    max_acc  <= max_nxt;
                    cnt      <= cnt_nxt;
                    // The published outputs only change here, so they hold across windows.
                    if (cnt_nxt == WIN_LEN) begin
                        stats_valid      <= 1'b1;
                        sum_rel_err      <= sum_nxt;
                        mean_rel_err     <= sum_nxt >> N_LOG2;
                        err_count        <= err_nxt;
                        zero_exact_count <= zero_nxt;
                        max_err_dist     <= max_nxt;
                        state            <= REPORT;
                    end else begin
                        state <= IDLE;
                    end
                end
                REPORT: begin
                    stats_valid <= 1'b0;
                    sum_acc     <= '0;
                    err_acc     <= '0;
                    zero_acc    <= '0;
                    max_acc     <= '0;
                    cnt         <= '0;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_approx_error_stats.sv
// tb/tb_approx_error_stats.sv - directed self-checking bench for approx_error_stats
module tb_approx_error_stats;

    logic        clk = 1'b0;
    logic        rst;
    logic        clear;
    logic        v2;
    logic        v8;
    logic [7:0]  approx;
    logic [7:0]  exact;

    logic        r2, sv2;
    logic [23:0] sum2, mean2;
    logic [2:0]  err2, zero2;
    logic [7:0]  max2;

    logic        r8, sv8;
    logic [23:0] sum8, mean8;
    logic [8:0]  err8, zero8;
    logic [7:0]  max8;

    int total = 0;
    int bad = 0;
    int pulses2 = 0;
    int pulses8 = 0;

    always #5 clk = ~clk;

    approx_error_stats #(.W(8), .N_LOG2(2), .SUM_W(24)) dut2 (
        .clk (clk), .rst (rst), .clear (clear),
        .in_valid (v2), .in_ready (r2), .approx (approx), .exact (exact),
        .stats_valid (sv2), .sum_rel_err (sum2), .mean_rel_err (mean2),
        .err_count (err2), .zero_exact_count (zero2), .max_err_dist (max2)
    );

    approx_error_stats #(.W(8), .N_LOG2(8), .SUM_W(24)) dut8 (
        .clk (clk), .rst (rst), .clear (clear),
        .in_valid (v8), .in_ready (r8), .approx (approx), .exact (exact),
        .stats_valid (sv8), .sum_rel_err (sum8), .mean_rel_err (mean8),
        .err_count (err8), .zero_exact_count (zero8), .max_err_dist (max8)
    );

    always @(negedge clk) begin
        if (sv2 === 1'b1) pulses2++;
        if (sv8 === 1'b1) pulses8++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge right after the accept edge.
    task automatic send(input bit big, input logic [7:0] a, input logic [7:0] e);
        int n = 0;
        while (!(big ? r8 : r2) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("ready_timeout", 32'd0, 32'd1);
        approx = a;
        exact  = e;
        if (big) v8 = 1'b1;
        else     v2 = 1'b1;
        @(negedge clk);
        v2 = 1'b0;
        v8 = 1'b0;
    endtask

    initial begin
        int hi_early;
        rst = 1'b1; clear = 1'b0; v2 = 1'b0; v8 = 1'b0; approx = '0; exact = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready",  32'(r2), 32'd1);
        check("rst_ready8", 32'(r8), 32'd1);
        check("rst_svalid", 32'(sv2), 32'd0);
        check("rst_sum",    32'(sum2), 32'd0);
        check("rst_mean",   32'(mean2), 32'd0);
        check("rst_err",    32'(err2), 32'd0);
        check("rst_zero",   32'(zero2), 32'd0);
        check("rst_max",    32'(max2), 32'd0);
        @(negedge clk);

        send(1'b0, 8'd10, 8'd12);
        send(1'b0, 8'd15, 8'd15);
        send(1'b0, 8'd0,  8'd0);
        send(1'b0, 8'd9,  8'd6);
        repeat (25) @(negedge clk);
        check("w1_pulses", 32'(pulses2), 32'd1);
        check("w1_sum",    32'(sum2), 32'd66);
        check("w1_mean",   32'(mean2), 32'd16);
        check("w1_err",    32'(err2), 32'd2);
        check("w1_zero",   32'(zero2), 32'd1);
        check("w1_max",    32'(max2), 32'd3);

        send(1'b0, 8'd20, 8'd10);
        hi_early = 0;
        for (int k = 1; k <= 16; k++) begin
            if (r2) hi_early++;
            @(negedge clk);
        end
        check("lat_busy_1_16", 32'(hi_early), 32'd0);
        check("lat_ready_17",  32'(r2), 32'd1);
        send(1'b0, 8'd5, 8'd0);
        check("zlat_busy_1", 32'(r2), 32'd0);
        @(negedge clk);
        check("zlat_ready_2", 32'(r2), 32'd1);
        send(1'b0, 8'd255, 8'd1);
        send(1'b0, 8'd0, 8'd255);
        repeat (25) @(negedge clk);
        check("w2_pulses", 32'(pulses2), 32'd2);
        check("w2_sum",    32'(sum2), 32'd25600);
        check("w2_mean",   32'(mean2), 32'd6400);
        check("w2_err",    32'(err2), 32'd4);
        check("w2_zero",   32'(zero2), 32'd1);
        check("w2_max",    32'(max2), 32'd255);
        repeat (5) @(negedge clk);
        check("w2_hold_sum", 32'(sum2), 32'd25600);
        check("w2_hold_sv",  32'(sv2), 32'd0);

        send(1'b0, 8'd20, 8'd10);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rst_sum",   32'(sum2), 32'd0);
        check("abort_rst_max",   32'(max2), 32'd0);
        check("abort_rst_ready", 32'(r2), 32'd1);
        @(negedge clk);
        send(1'b0, 8'd1, 8'd2);
        send(1'b0, 8'd3, 8'd3);
        repeat (3) @(negedge clk);
        clear = 1'b1; v2 = 1'b1; approx = 8'd200; exact = 8'd1;
        #1;
        check("clear_ready_low", 32'(r2), 32'd0);
        @(negedge clk);
        clear = 1'b0; v2 = 1'b0;
        send(1'b0, 8'd3, 8'd4);
        send(1'b0, 8'd8, 8'd8);
        send(1'b0, 8'd4, 8'd2);
        send(1'b0, 8'd7, 8'd5);
        repeat (25) @(negedge clk);
        check("w3_pulses", 32'(pulses2), 32'd3);
        check("w3_sum",    32'(sum2), 32'd165);
        check("w3_mean",   32'(mean2), 32'd41);
        check("w3_err",    32'(err2), 32'd3);
        check("w3_zero",   32'(zero2), 32'd0);
        check("w3_max",    32'(max2), 32'd2);

        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                logic [7:0] p;
                p = 8'(a * b);
                send(1'b1, p, p);
            end
        end
        repeat (25) @(negedge clk);
        check("sweep_pulses", 32'(pulses8), 32'd1);
        check("sweep_sum",    32'(sum8), 32'd0);
        check("sweep_mean",   32'(mean8), 32'd0);
        check("sweep_err",    32'(err8), 32'd0);
        check("sweep_zero",   32'(zero8), 32'd31);
        check("sweep_max",    32'(max8), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
